// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the codec I2C configuration path: arbiter state
// encoding, the 24-bit write-word layout and default device addresses.
package i2c_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Write word = {dev_addr, reg_addr, reg_data}, one byte each
  localparam int WORD_W   = 24;
  localparam int FIELD_W  = 8;
  localparam int DEV_LSB  = 16;
  localparam int REG_LSB  = 8;
  localparam int DATA_LSB = 0;

  localparam logic [FIELD_W-1:0] ADC_DEV_ADDR = 8'h20;

  // Assemble a write word from its three fields
  function automatic logic [WORD_W-1:0] make_wr_word(
    input logic [FIELD_W-1:0] dev,
    input logic [FIELD_W-1:0] rega,
    input logic [FIELD_W-1:0] dat
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[DEV_LSB  +: FIELD_W] = dev;
    w[REG_LSB  +: FIELD_W] = rega;
    w[DATA_LSB +: FIELD_W] = dat;
    return w;
  endfunction

  // 8-bit counter increment that sticks at 255
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/i2c_wr_arbiter.sv
// Two-port arbiter in front of the single 3-byte I2C write engine.
// Port 0 is the power-up register sequencer, port 1 the runtime updater.
// Handles NACK retries, hang timeout and the idle gap between writes.
module i2c_wr_arbiter
  import i2c_cfg_pkg::*;
#(
  parameter int MAX_RETRY   = 2,
  parameter int TIMEOUT_CYC = 4096,
  parameter int GAP_CYC     = 4,
  parameter int RR_MODE     = 0
) (
  input  logic              clock_i2c,
  input  logic              rst,
  input  logic              req0,
  input  logic [WORD_W-1:0] wdata0,
  output logic              done0,
  output logic              err0,
  input  logic              req1,
  input  logic [WORD_W-1:0] wdata1,
  output logic              done1,
  output logic              err1,
  output logic              start,
  output logic [WORD_W-1:0] i2c_data,
  input  logic              tr_end,
  input  logic              ack,
  output logic              busy,
  output logic              timeout_flag,
  output logic [7:0]        nack_cnt
);

  localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam int GAP_W = $clog2(GAP_CYC);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);
  localparam logic [2:0] RETRY_MAX = 3'(MAX_RETRY);

  state_t           state;
  logic             owner;       // 0 = port 0, 1 = port 1
  logic             rr_last;     // port whose write finished most recently
  logic             retry_pend;
  logic [2:0]       retry_cnt;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;
  logic             any_req;
  logic             pick1;

  assign busy = (state != ST_IDLE);

  // Grant decision for the IDLE state: fixed priority or alternate on ties
  always_comb begin
    any_req = req0 | req1;
    if (RR_MODE == 0) pick1 = ~req0;
    else              pick1 = req1 & (~req0 | ~rr_last);
  end

  // Arbiter FSM: grant, watch the engine, retry/abort, enforce idle gap
  always_ff @(posedge clock_i2c) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= 1'b0;
      rr_last      <= 1'b1;
      retry_pend   <= 1'b0;
      retry_cnt    <= '0;
      timer        <= '0;
      gap_cnt      <= '0;
      start        <= 1'b0;
      i2c_data     <= '0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      err0         <= 1'b0;
      err1         <= 1'b0;
      timeout_flag <= 1'b0;
      nack_cnt     <= '0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      err0  <= 1'b0;
      err1  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            owner      <= pick1;
            i2c_data   <= pick1 ? wdata1 : wdata0;
            start      <= 1'b1;
            retry_cnt  <= '0;
            retry_pend <= 1'b0;
            timer      <= '0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          if (tr_end) begin
            // A completion seen on the last timer cycle still counts as tr_end
            start   <= 1'b0;
            gap_cnt <= '0;
            state   <= ST_GAP;
            if (ack) begin
              retry_pend <= 1'b0;
              rr_last    <= owner;
              if (owner) done1 <= 1'b1;
              else       done0 <= 1'b1;
            end else begin
              nack_cnt <= sat_inc8(nack_cnt);
              if (retry_cnt < RETRY_MAX) begin
                retry_cnt  <= retry_cnt + 1'b1;
                retry_pend <= 1'b1;
              end else begin
                retry_pend <= 1'b0;
                rr_last    <= owner;
                if (owner) begin done1 <= 1'b1; err1 <= 1'b1; end
                else       begin done0 <= 1'b1; err0 <= 1'b1; end
              end
            end
          end else if (timer == TMR_LAST) begin
            // Engine hung: abort without retrying
            start        <= 1'b0;
            gap_cnt      <= '0;
            state        <= ST_GAP;
            retry_pend   <= 1'b0;
            timeout_flag <= 1'b1;
            rr_last      <= owner;
            if (owner) begin done1 <= 1'b1; err1 <= 1'b1; end
            else       begin done0 <= 1'b1; err0 <= 1'b1; end
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (retry_pend) begin
              start      <= 1'b1;
              timer      <= '0;
              retry_pend <= 1'b0;
              state      <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
// Directed bench for i2c_wr_arbiter: a fixed-priority instance (dut) driven
// through write, retry, timeout and reset scenarios, and a round-robin
// instance (dut_rr) for the tie-break behaviour.
module tb_i2c_wr_arbiter;
  import i2c_cfg_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0, req1, tr_end, ack;
  logic [23:0] wdata0, wdata1;
  logic        done0, err0, done1, err1, start, busy, timeout_flag;
  logic [23:0] i2c_data;
  logic [7:0]  nack_cnt;

  logic        r_req0, r_req1, r_tr_end, r_ack;
  logic [23:0] r_wdata0, r_wdata1;
  logic        r_done0, r_err0, r_done1, r_err1, r_start, r_busy, r_timeout_flag;
  logic [23:0] r_i2c_data;
  logic [7:0]  r_nack_cnt;

  int checks = 0;
  int errors = 0;

  i2c_wr_arbiter #(.MAX_RETRY(2), .TIMEOUT_CYC(4096), .GAP_CYC(4), .RR_MODE(0)) dut (
    .clock_i2c(clk), .rst(rst),
    .req0(req0), .wdata0(wdata0), .done0(done0), .err0(err0),
    .req1(req1), .wdata1(wdata1), .done1(done1), .err1(err1),
    .start(start), .i2c_data(i2c_data), .tr_end(tr_end), .ack(ack),
    .busy(busy), .timeout_flag(timeout_flag), .nack_cnt(nack_cnt)
  );

  i2c_wr_arbiter #(.MAX_RETRY(2), .TIMEOUT_CYC(4096), .GAP_CYC(4), .RR_MODE(1)) dut_rr (
    .clock_i2c(clk), .rst(rst),
    .req0(r_req0), .wdata0(r_wdata0), .done0(r_done0), .err0(r_err0),
    .req1(r_req1), .wdata1(r_wdata1), .done1(r_done1), .err1(r_err1),
    .start(r_start), .i2c_data(r_i2c_data), .tr_end(r_tr_end), .ack(r_ack),
    .busy(r_busy), .timeout_flag(r_timeout_flag), .nack_cnt(r_nack_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0 = 0; req1 = 0; tr_end = 0; ack = 0; wdata0 = '0; wdata1 = '0;
    r_req0 = 0; r_req1 = 0; r_tr_end = 0; r_ack = 0; r_wdata0 = '0; r_wdata1 = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Engine stand-in for dut: called in the first cycle start is high,
  // raises tr_end in cycle lat of the attempt, returns in the cycle after.
  task automatic engine_resp(input int lat, input bit ackv, output int hi);
    hi = 0;
    for (int k = 1; k <= lat; k++) begin
      if (start === 1'b1) hi++;
      if (k == lat) begin tr_end = 1'b1; ack = ackv; end
      tick();
    end
    tr_end = 1'b0;
    ack = 1'b0;
  endtask

  // Counts cycles with start low until it rises (bounded), noting done pulses
  task automatic wait_start(input int max, output int idle, output bit sd0, output bit sd1, output bit ok);
    idle = 0; sd0 = 0; sd1 = 0;
    while (start !== 1'b1 && idle < max) begin
      if (done0 === 1'b1) sd0 = 1;
      if (done1 === 1'b1) sd1 = 1;
      tick();
      idle++;
    end
    ok = (start === 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start got %0b want 0", start); end
    checks++; if (i2c_data !== 24'h0) begin errors++; $display("FAIL reset_data got %h want 000000", i2c_data); end
    checks++; if ({done0, done1, err0, err1} !== 4'b0) begin errors++; $display("FAIL reset_done_err got %b want 0000", {done0, done1, err0, err1}); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_tflag got %0b want 0", timeout_flag); end
    checks++; if (nack_cnt !== 8'd0) begin errors++; $display("FAIL reset_nack got %0d want 0", nack_cnt); end
    checks++; if ({r_start, r_busy} !== 2'b00) begin errors++; $display("FAIL reset_rr got %b want 00", {r_start, r_busy}); end
  endtask

  task automatic test_single_write();
    int hi;
    do_reset();
    req0 = 1'b1;
    wdata0 = make_wr_word(ADC_DEV_ADDR, 8'h0B, 8'h0C);
    tick();
    checks++; if (start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_start got start=%0b busy=%0b want 1 1", start, busy); end
    checks++; if (i2c_data !== 24'h200B0C) begin errors++; $display("FAIL single_data got %h want 200b0c", i2c_data); end
    engine_resp(40, 1'b1, hi);
    checks++; if (hi != 40) begin errors++; $display("FAIL single_start_len got %0d want 40", hi); end
    checks++; if (start !== 1'b0 || done0 !== 1'b1 || err0 !== 1'b0 || done1 !== 1'b0) begin
      errors++; $display("FAIL single_done got start=%0b done0=%0b err0=%0b done1=%0b want 0 1 0 0", start, done0, err0, done1); end
    req0 = 1'b0;
    tick();
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL single_done_pulse got %0b want 0", done0); end
  endtask

  task automatic test_priority();
    int hi, idle; bit sd0, sd1, ok;
    do_reset();
    req0 = 1; req1 = 1; wdata0 = 24'h20_1111; wdata1 = 24'h20_2222;
    tick();
    checks++; if (start !== 1'b1 || i2c_data !== 24'h201111) begin errors++; $display("FAIL prio_first got start=%0b data=%h want 1 201111", start, i2c_data); end
    engine_resp(3, 1'b1, hi);
    checks++; if (done0 !== 1'b1 || done1 !== 1'b0) begin errors++; $display("FAIL prio_done0 got done0=%0b done1=%0b want 1 0", done0, done1); end
    req0 = 0;
    wait_start(50, idle, sd0, sd1, ok);
    checks++; if (!ok || idle < 5) begin errors++; $display("FAIL prio_gap got idle=%0d ok=%0b want >=5 1", idle, ok); end
    checks++; if (i2c_data !== 24'h202222 || sd1) begin errors++; $display("FAIL prio_second got data=%h done1_seen=%0b want 202222 0", i2c_data, sd1); end
    engine_resp(2, 1'b1, hi);
    checks++; if (done1 !== 1'b1 || err1 !== 1'b0 || done0 !== 1'b0) begin errors++; $display("FAIL prio_done1 got done1=%0b err1=%0b done0=%0b want 1 0 0", done1, err1, done0); end
    req1 = 0;
    tick();
  endtask

  task automatic test_nack_retry();
    int hi, idle; bit sd0, sd1, ok;
    do_reset();
    req1 = 1; wdata1 = 24'h20_0A55;
    tick();
    for (int a = 0; a < 3; a++) begin
      if (a > 0) begin
        wait_start(50, idle, sd0, sd1, ok);
        checks++; if (!ok || idle < 4 || sd1) begin errors++; $display("FAIL retry_gap%0d got idle=%0d ok=%0b done1_seen=%0b want >=4 1 0", a, idle, ok, sd1); end
      end
      checks++; if (start !== 1'b1 || i2c_data !== 24'h200A55) begin errors++; $display("FAIL retry_attempt%0d got start=%0b data=%h want 1 200a55", a, start, i2c_data); end
      engine_resp(5, (a == 2), hi);
      if (a < 2) begin
        checks++; if (done1 !== 1'b0 || nack_cnt !== 8'(a + 1)) begin errors++; $display("FAIL retry_nack%0d got done1=%0b nack=%0d want 0 %0d", a, done1, nack_cnt, a + 1); end
      end
    end
    checks++; if (done1 !== 1'b1 || err1 !== 1'b0 || nack_cnt !== 8'd2) begin errors++; $display("FAIL retry_done got done1=%0b err1=%0b nack=%0d want 1 0 2", done1, err1, nack_cnt); end
    req1 = 0;
    tick();
  endtask

  task automatic test_nack_exhaust();
    int hi, idle, extra; bit sd0, sd1, ok;
    do_reset();
    req0 = 1; wdata0 = 24'h20_0301;
    tick();
    for (int a = 0; a < 3; a++) begin
      if (a > 0) begin
        wait_start(50, idle, sd0, sd1, ok);
        checks++; if (!ok || idle < 4 || sd0) begin errors++; $display("FAIL exh_gap%0d got idle=%0d ok=%0b done0_seen=%0b want >=4 1 0", a, idle, ok, sd0); end
      end
      engine_resp(5, 1'b0, hi);
    end
    checks++; if (done0 !== 1'b1 || err0 !== 1'b1 || nack_cnt !== 8'd3) begin errors++; $display("FAIL exh_done got done0=%0b err0=%0b nack=%0d want 1 1 3", done0, err0, nack_cnt); end
    req0 = 0;
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      if (start === 1'b1) extra++;
      tick();
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL exh_no_fourth got %0d start cycles want 0", extra); end
  endtask

  task automatic test_timeout();
    int hi;
    do_reset();
    req0 = 1; wdata0 = 24'h20_0777;
    tick();
    hi = 0;
    while (start === 1'b1 && hi < 5000) begin
      hi++;
      tick();
    end
    checks++; if (hi != 4096) begin errors++; $display("FAIL tmo_len got %0d want 4096", hi); end
    checks++; if (done0 !== 1'b1 || err0 !== 1'b1 || timeout_flag !== 1'b1) begin errors++; $display("FAIL tmo_done got done0=%0b err0=%0b tflag=%0b want 1 1 1", done0, err0, timeout_flag); end
    req0 = 0;
    repeat (1000) tick();
    checks++; if (timeout_flag !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL tmo_sticky got tflag=%0b busy=%0b want 1 0", timeout_flag, busy); end
  endtask

  task automatic test_reset_mid_write();
    int hi, idle, dn; bit sd0, sd1, ok;
    do_reset();
    req0 = 1; wdata0 = 24'h20_0F0F;
    tick();
    engine_resp(3, 1'b0, hi);
    checks++; if (nack_cnt !== 8'd1) begin errors++; $display("FAIL rstmid_nack got %0d want 1", nack_cnt); end
    wait_start(50, idle, sd0, sd1, ok);
    tick(); tick();
    checks++; if (start !== 1'b1 || !ok) begin errors++; $display("FAIL rstmid_inflight got start=%0b want 1", start); end
    rst = 1; req0 = 0;
    tick();
    rst = 0;
    checks++; if (start !== 1'b0 || busy !== 1'b0 || done0 !== 1'b0 || nack_cnt !== 8'd0) begin
      errors++; $display("FAIL rstmid_state got start=%0b busy=%0b done0=%0b nack=%0d want 0 0 0 0", start, busy, done0, nack_cnt); end
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (done0 === 1'b1 || start === 1'b1) dn++;
      tick();
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", dn); end
    req0 = 1; wdata0 = 24'h20_1234;
    tick();
    checks++; if (start !== 1'b1 || i2c_data !== 24'h201234) begin errors++; $display("FAIL rstmid_regrant got start=%0b data=%h want 1 201234", start, i2c_data); end
    engine_resp(2, 1'b1, hi);
    checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin errors++; $display("FAIL rstmid_done got done0=%0b err0=%0b want 1 0", done0, err0); end
    req0 = 0;
    tick();
  endtask

  // One-cycle engine response for the round-robin instance
  task automatic rr_serve();
    r_tr_end = 1; r_ack = 1;
    tick();
    r_tr_end = 0; r_ack = 0;
  endtask

  task automatic rr_wait_idle(output bit ok);
    int n;
    n = 0;
    while (r_busy !== 1'b0 && n < 50) begin tick(); n++; end
    ok = (r_busy === 1'b0);
  endtask

  task automatic test_round_robin();
    int n; bit ok;
    do_reset();
    // Tie straight after reset goes to port 0
    r_req0 = 1; r_req1 = 1; r_wdata0 = 24'h20_A0A0; r_wdata1 = 24'h20_B1B1;
    tick();
    checks++; if (r_start !== 1'b1 || r_i2c_data !== 24'h20A0A0) begin errors++; $display("FAIL rr_first_tie got start=%0b data=%h want 1 20a0a0", r_start, r_i2c_data); end
    rr_serve();
    checks++; if (r_done0 !== 1'b1 || r_done1 !== 1'b0) begin errors++; $display("FAIL rr_done0 got done0=%0b done1=%0b want 1 0", r_done0, r_done1); end
    r_req0 = 0;
    n = 0;
    while (r_start !== 1'b1 && n < 50) begin tick(); n++; end
    checks++; if (r_start !== 1'b1 || r_i2c_data !== 24'h20B1B1) begin errors++; $display("FAIL rr_then1 got start=%0b data=%h want 1 20b1b1", r_start, r_i2c_data); end
    rr_serve();
    r_req1 = 0;
    rr_wait_idle(ok);
    // Port 0 alone, so port 0 becomes the last served
    r_req0 = 1; r_wdata0 = 24'h20_C2C2;
    tick();
    rr_serve();
    checks++; if (r_done0 !== 1'b1) begin errors++; $display("FAIL rr_solo0 got done0=%0b want 1", r_done0); end
    r_req0 = 0;
    rr_wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_idle got busy=%0b want 0", r_busy); end
    // Tie with port 0 served last goes to port 1
    r_req0 = 1; r_req1 = 1; r_wdata0 = 24'h20_D3D3; r_wdata1 = 24'h20_E4E4;
    tick();
    checks++; if (r_start !== 1'b1 || r_i2c_data !== 24'h20E4E4) begin errors++; $display("FAIL rr_tie_port1 got start=%0b data=%h want 1 20e4e4", r_start, r_i2c_data); end
    rr_serve();
    checks++; if (r_done1 !== 1'b1 || r_done0 !== 1'b0) begin errors++; $display("FAIL rr_done1 got done1=%0b done0=%0b want 1 0", r_done1, r_done0); end
    r_req1 = 0;
    n = 0;
    while (r_start !== 1'b1 && n < 50) begin tick(); n++; end
    rr_serve();
    r_req0 = 0;
    rr_wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_nack_retry();
    test_nack_exhaust();
    test_timeout();
    test_reset_mid_write();
    test_round_robin();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_wr_arbiter.md
Name: i2c_wr_arbiter

Overview:
Shares the single 3-byte I2C write engine (i2c_com: start / i2c_data / tr_end / ack) between two requesters: port 0, the power-up codec register sequencer, and port 1, the runtime register updater for gain, mute and volume writes. The block issues each write to the engine and enforces a minimum idle gap between writes. It retries a write that is NACKed, aborts a write that hangs, and returns a done/err result to the requester that owns the write. It runs in the I2C control clock domain, alongside the codec configuration logic.

Parameters:
MAX_RETRY, 2, extra attempts after a NACK before err is reported (0..7)
TIMEOUT_CYC, 4096, clock_i2c cycles allowed from start rising to tr_end before abort
GAP_CYC, 4, minimum clock_i2c cycles with start=0 between attempts (>=2)
RR_MODE, 0, arbitration: 0 = fixed priority with port 0 high, 1 = round-robin

Ports:
clock_i2c  in  1  the block's only clock (the I2C control clock)
rst  in  1  synchronous, active-high reset
req0  in  1  port 0 request; level signal, held until done0
wdata0  in  24  port 0 write {dev_addr, reg_addr, reg_data}; stable while req0=1
done0  out  1  one-cycle pulse: port 0 write finished
err0  out  1  valid with done0; 1 = NACK after all retries, or timeout
req1  in  1  port 1 request
wdata1  in  24  port 1 write
done1  out  1  one-cycle pulse: port 1 write finished
err1  out  1  valid with done1
start  out  1  to engine; high starts a write, held until tr_end
i2c_data  out  24  to engine; stable while start=1
tr_end  in  1  from engine; write finished
ack  in  1  from engine; sampled when tr_end=1; 1 = all three bytes ACKed
busy  out  1  high in any state other than IDLE
timeout_flag  out  1  sticky; set on any timeout, cleared only by rst
nack_cnt  out  8  saturating count of NACKed attempts; cleared by rst

Behaviour:
- Clock and reset: a single clock, clock_i2c. Reset is synchronous and active-high on rst.
- Reset values: start=0, i2c_data=0, done*=0, err*=0, busy=0, timeout_flag=0, nack_cnt=0, state=IDLE, rr_last=1 (so port 0 wins the first round-robin tie).
- Reset mid-write: start drops at the next edge; no done pulse is issued. The engine is reset separately.
- States: IDLE, WAIT, GAP.
- IDLE:
  - If req0 or req1 is high, select the owner. RR_MODE=0: port 0 wins. RR_MODE=1: when both are high, the port not served last wins.
  - At the same edge: i2c_data <= selected wdata, start <= 1, retry_cnt <= 0, timer <= 0, state <= WAIT.
  - Latency: start rises 1 cycle after req is sampled.
- WAIT: timer increments every cycle.
  - tr_end=1 and ack=1: start <= 0, done<owner> <= 1 with err=0, state <= GAP, retry_pend <= 0.
  - tr_end=1 and ack=0: start <= 0, nack_cnt increments (saturating at 255).
    - If retry_cnt < MAX_RETRY: retry_cnt increments, retry_pend <= 1, state <= GAP; no done pulse.
    - Otherwise: done<owner> <= 1 with err=1, retry_pend <= 0, state <= GAP.
  - timer = TIMEOUT_CYC-1 and tr_end=0: start <= 0, done<owner> <= 1 with err=1, timeout_flag <= 1, state <= GAP. No retry after a timeout.
  - tr_end and timeout in the same cycle: tr_end takes precedence.
- GAP:
  - start is held at 0 for GAP_CYC cycles; i2c_data holds its value.
  - Then, if retry_pend: start <= 1, timer <= 0, state <= WAIT, with the same i2c_data and owner.
  - Otherwise state <= IDLE. Arbitration resumes only in IDLE, which gives at least 1 extra cycle so the requester can drop req after done.
- Handshake rules:
  - A requester keeps req high until its done pulse and drops it the cycle after.
  - If req drops mid-write, the write still completes and done still pulses. wdata is latched at grant, so later changes do not affect the write in flight.
  - done0 and done1 are never high in the same cycle.
- rr_last updates to the owner when its done pulse is issued.
- tr_end arriving in IDLE or GAP is ignored.

Decomposition:
- Shared package i2c_cfg_pkg: state encoding (ST_IDLE, ST_WAIT, ST_GAP), the 24-bit write-word layout (field offsets for dev/reg/data), default device addresses (ADC 8'h20).
- No sub-module; the arbiter, FSM and counters are one module of roughly 150–250 lines.

Test Plan:
- Single write, ack=1: req0, wdata0=24'h20_0B0C, engine model returns tr_end at cycle 40 → start high cycles 1..40, i2c_data=24'h200B0C, done0 one cycle after tr_end, err0=0.
- Both requesting: req0 and req1 high in the same cycle → RR_MODE=0: port 0 served first, port 1 started ≥GAP_CYC+1 cycles after done0. RR_MODE=1 with rr_last=0: port 1 served first.
- NACK then ACK: ack=0 on the first two attempts, 1 on the third, MAX_RETRY=2 → 3 start pulses separated by ≥4 idle cycles, done1 with err1=0, nack_cnt=2.
- NACK exhaustion: ack=0 on every attempt → 3 attempts, done0 with err0=1, nack_cnt=3, no fourth start.
- Timeout: tr_end never arrives → start drops at cycle 4096, done0 with err0=1, timeout_flag=1 and still 1 after 1000 more cycles.
- Reset mid-write: rst asserted while start=1 in WAIT → next edge: start=0, busy=0, no done pulse, nack_cnt=0; a new req0 after reset is granted normally.
